// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter that shares one memory's read and write channels among NUM_REQ requesters.
// One transaction is outstanding at a time; responses are routed back to the issuing requester.
module memory_access_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int VIRT_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*VIRT_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_mask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [3:0]                           rsp_status,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic                                 mem_read_req_valid,
    output logic [VIRT_ADDR_WIDTH-1:0]           mem_read_req_addr,
    output logic [DATA_WIDTH/8-1:0]              mem_read_req_mask,
    input  logic                                 mem_read_req_ready,
    input  logic                                 mem_read_resp_valid,
    input  logic [DATA_WIDTH-1:0]                mem_read_resp_data,
    input  logic [3:0]                           mem_read_resp_status,
    output logic                                 mem_read_resp_ready,
    output logic                                 mem_write_req_valid,
    output logic [VIRT_ADDR_WIDTH-1:0]           mem_write_req_addr,
    output logic [DATA_WIDTH/8-1:0]              mem_write_req_mask,
    output logic [DATA_WIDTH-1:0]                mem_write_req_data,
    input  logic                                 mem_write_req_ready,
    input  logic                                 mem_write_resp_valid,
    input  logic [3:0]                           mem_write_resp_status,
    output logic                                 mem_write_resp_ready,
    output logic                                 busy,
    output logic [7:0]                           drop_count
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int TMR_W      = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [IDX_W-1:0]           owner_q, owner_d;
    logic                       write_q, write_d;
    logic [VIRT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MASK_WIDTH-1:0]      mask_q, mask_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [3:0]                 status_q, status_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [7:0]                 drop_q, drop_d;

    logic [VIRT_ADDR_WIDTH-1:0] addr_slot  [NUM_REQ];
    logic [MASK_WIDTH-1:0]      mask_slot  [NUM_REQ];
    logic [DATA_WIDTH-1:0]      wdata_slot [NUM_REQ];

    logic                       grant_found;
    logic [IDX_W-1:0]           grant_idx;
    logic [IDX_W-1:0]           cand_idx;
    int                         cand;
    logic [8:0]                 drop_sum;
    logic                       in_idle;
    logic                       mem_req_accepted;
    logic                       mem_resp_seen;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign addr_slot[gi]  = req_addr[gi*VIRT_ADDR_WIDTH +: VIRT_ADDR_WIDTH];
        assign mask_slot[gi]  = req_mask[gi*MASK_WIDTH +: MASK_WIDTH];
        assign wdata_slot[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest candidate back to last_grant+1 so the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(last_grant_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign in_idle          = (state_q == ST_IDLE);
    assign drop_sum         = {1'b0, drop_q} + {8'd0, mem_read_resp_valid}
                              + {8'd0, mem_write_resp_valid};
    assign mem_req_accepted = write_q ? mem_write_req_ready : mem_read_req_ready;
    assign mem_resp_seen    = write_q ? mem_write_resp_valid : mem_read_resp_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        status_d     = status_q;
        timer_d      = timer_q;
        drop_d       = drop_q;
        case (state_q)
            ST_IDLE: begin
                // Responses are only counted as strays while idle.
                drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
                if (grant_found) begin
                    owner_d = grant_idx;
                    write_d = req_write[grant_idx];
                    addr_d  = addr_slot[grant_idx];
                    mask_d  = mask_slot[grant_idx];
                    wdata_d = wdata_slot[grant_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_accepted) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (mem_resp_seen) begin
                    status_d = write_q ? mem_write_resp_status : mem_read_resp_status;
                    rdata_d  = write_q ? '0 : mem_read_resp_data;
                    state_d  = ST_RETURN;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    status_d = 4'hF;
                    rdata_d  = '0;
                    state_d  = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            status_q     <= '0;
            timer_q      <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            timer_q      <= timer_d;
            drop_q       <= drop_d;
        end
    end

    // Handshake outputs are forced to their idle values while reset is held.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign req_ready[gi] = !rst && in_idle && grant_found && (grant_idx == IDX_W'(gi));
        assign rsp_valid[gi] = !rst && (state_q == ST_RETURN) && (owner_q == IDX_W'(gi));
    end

    assign rsp_data   = rdata_q;
    assign rsp_status = status_q;
    assign busy       = !rst && !in_idle;
    assign drop_count = drop_q;

    assign mem_read_req_valid   = !rst && (state_q == ST_ISSUE) && !write_q;
    assign mem_read_req_addr    = addr_q;
    assign mem_read_req_mask    = mask_q;
    assign mem_read_resp_ready  = rst || in_idle || ((state_q == ST_WAIT) && !write_q);

    assign mem_write_req_valid  = !rst && (state_q == ST_ISSUE) && write_q;
    assign mem_write_req_addr   = addr_q;
    assign mem_write_req_mask   = mask_q;
    assign mem_write_req_data   = wdata_q;
    assign mem_write_resp_ready = rst || in_idle || ((state_q == ST_WAIT) && write_q);

endmodule
